// File: rtl/mipi_tx_lane_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mipi_tx_lane_sequencer_pkg
//  Description : Shared MIPI D-PHY lane definitions (sync byte, LP line
//                encodings, lane state enumeration) used by TX and RX sides.
//  Revision    : 1.0 - initial release
// ============================================================================
package mipi_tx_lane_sequencer_pkg;

   // HS leader sync byte, transmitted LSB first
   localparam logic [7:0] c_SYNC_BYTE = 8'hB8;

   // LP line states as {Dp,Dn}
   localparam logic [1:0] c_LP_11 = 2'b11;
   localparam logic [1:0] c_LP_01 = 2'b01;
   localparam logic [1:0] c_LP_00 = 2'b00;

   // Lane sequencing states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LP01    = 3'd1,
      ST_LP00    = 3'd2,
      ST_HS_ZERO = 3'd3,
      ST_SYNC    = 3'd4,
      ST_DATA    = 3'd5,
      ST_TRAIL   = 3'd6,
      ST_GAP     = 3'd7
   } lane_state_t;

   // Bits needed for a counter that must reach max_val
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   // Trail byte is the inverse of the last transmitted bit, repeated
   function automatic logic [7:0] trail_byte(input logic last_bit);
      return {8{~last_bit}};
   endfunction

endpackage
`default_nettype wire

// File: rtl/mipi_tx_lane_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mipi_tx_lane_sequencer
//  Description : D-PHY TX data lane sequencer. Walks LP-11 -> LP-01 -> LP-00,
//                emits the HS zero leader and sync byte, streams payload bytes,
//                appends trail bytes and enforces an LP-11 gap between bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module mipi_tx_lane_sequencer
   import mipi_tx_lane_sequencer_pkg::*;
#(
   parameter int LPX_CYCLES     = 2,
   parameter int HS_ZERO_BYTES  = 4,
   parameter int HS_TRAIL_BYTES = 2,
   parameter int LP_GAP_CYCLES  = 8
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic [7:0] byte_i,
   input  logic       byte_valid_i,
   input  logic       last_i,
   output logic       byte_ready_o,
   output logic [7:0] hs_byte_o,
   output logic       hs_en_o,
   output logic [1:0] lp_o,
   output logic       busy_o,
   output logic       underflow_o
);

   // One shared counter, wide enough for the largest parameter
   localparam int c_MAX_AB  = (LPX_CYCLES > HS_ZERO_BYTES) ? LPX_CYCLES : HS_ZERO_BYTES;
   localparam int c_MAX_CD  = (HS_TRAIL_BYTES > LP_GAP_CYCLES) ? HS_TRAIL_BYTES : LP_GAP_CYCLES;
   localparam int c_CNT_MAX = (c_MAX_AB > c_MAX_CD) ? c_MAX_AB : c_MAX_CD;
   localparam int c_CW      = cnt_width(c_CNT_MAX);

   // Outputs lag the state by one register stage, so the line shows one
   // LP-11 cycle from IDLE after GAP; GAP covers the remainder of the gap.
   localparam int c_GAP_STATES = (LP_GAP_CYCLES > 1) ? LP_GAP_CYCLES - 1 : 1;

   localparam logic [c_CW-1:0] c_ONE        = c_CW'(1);
   localparam logic [c_CW-1:0] c_LPX_LAST   = c_CW'(LPX_CYCLES - 1);
   localparam logic [c_CW-1:0] c_ZERO_LAST  = c_CW'(HS_ZERO_BYTES - 1);
   localparam logic [c_CW-1:0] c_TRAIL_LAST = c_CW'(HS_TRAIL_BYTES - 1);
   localparam logic [c_CW-1:0] c_GAP_LAST   = c_CW'(c_GAP_STATES - 1);

   lane_state_t      r_state;
   lane_state_t      w_state_nxt;
   logic [c_CW-1:0]  r_cnt;
   logic [c_CW-1:0]  w_cnt_nxt;
   logic             r_last_bit;

   // Payload is only taken while streaming and never in a reset cycle
   assign byte_ready_o = (r_state == ST_DATA) && reset_n_i;

   // State and counter register
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state and counter logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + c_ONE;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (byte_valid_i) begin
               w_state_nxt = ST_LP01;
            end
         end
         ST_LP01: begin
            if (r_cnt == c_LPX_LAST) begin
               w_state_nxt = ST_LP00;
               w_cnt_nxt   = '0;
            end
         end
         ST_LP00: begin
            if (r_cnt == c_LPX_LAST) begin
               w_state_nxt = ST_HS_ZERO;
               w_cnt_nxt   = '0;
            end
         end
         ST_HS_ZERO: begin
            if (r_cnt == c_ZERO_LAST) begin
               w_state_nxt = ST_SYNC;
               w_cnt_nxt   = '0;
            end
         end
         ST_SYNC: begin
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = '0;
         end
         ST_DATA: begin
            w_cnt_nxt = '0;
            if (!byte_valid_i) begin
               // The starved cycle itself emits the first trail byte
               if (HS_TRAIL_BYTES > 1) begin
                  w_state_nxt = ST_TRAIL;
                  w_cnt_nxt   = c_ONE;
               end else begin
                  w_state_nxt = ST_GAP;
               end
            end else if (last_i) begin
               w_state_nxt = ST_TRAIL;
            end
         end
         ST_TRAIL: begin
            if (r_cnt == c_TRAIL_LAST) begin
               w_state_nxt = ST_GAP;
               w_cnt_nxt   = '0;
            end
         end
         ST_GAP: begin
            if (r_cnt == c_GAP_LAST) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Registered lane outputs derived from the current state and handshake
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         lp_o        <= c_LP_11;
         hs_en_o     <= 1'b0;
         hs_byte_o   <= 8'h00;
         busy_o      <= 1'b0;
         underflow_o <= 1'b0;
         r_last_bit  <= 1'b0;
      end else begin
         lp_o        <= c_LP_11;
         hs_en_o     <= 1'b0;
         hs_byte_o   <= 8'h00;
         busy_o      <= (r_state != ST_IDLE);
         underflow_o <= (r_state == ST_DATA) && !byte_valid_i;
         case (r_state)
            ST_LP01: begin
               lp_o <= c_LP_01;
            end
            ST_LP00: begin
               lp_o <= c_LP_00;
            end
            ST_HS_ZERO: begin
               lp_o    <= c_LP_00;
               hs_en_o <= 1'b1;
            end
            ST_SYNC: begin
               lp_o       <= c_LP_00;
               hs_en_o    <= 1'b1;
               hs_byte_o  <= c_SYNC_BYTE;
               r_last_bit <= c_SYNC_BYTE[7];
            end
            ST_DATA: begin
               lp_o    <= c_LP_00;
               hs_en_o <= 1'b1;
               if (byte_valid_i) begin
                  hs_byte_o  <= byte_i;
                  r_last_bit <= byte_i[7];
               end else begin
                  hs_byte_o <= trail_byte(r_last_bit);
               end
            end
            ST_TRAIL: begin
               lp_o      <= c_LP_00;
               hs_en_o   <= 1'b1;
               hs_byte_o <= trail_byte(r_last_bit);
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mipi_tx_lane_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mipi_tx_lane_sequencer
//  Description : Directed self-checking bench for mipi_tx_lane_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mipi_tx_lane_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] byte_in;
   logic       valid;
   logic       last;
   logic       ready;
   logic [7:0] hs_byte;
   logic       hs_en;
   logic [1:0] lp;
   logic       busy;
   logic       underflow;

   always #5 clk = ~clk;

   mipi_tx_lane_sequencer #(
      .LPX_CYCLES     (2),
      .HS_ZERO_BYTES  (4),
      .HS_TRAIL_BYTES (2),
      .LP_GAP_CYCLES  (8)
   ) dut (
      .clk_i        (clk),
      .reset_n_i    (reset_n),
      .byte_i       (byte_in),
      .byte_valid_i (valid),
      .last_i       (last),
      .byte_ready_o (ready),
      .hs_byte_o    (hs_byte),
      .hs_en_o      (hs_en),
      .lp_o         (lp),
      .busy_o       (busy),
      .underflow_o  (underflow)
   );

   int n_err = 0;
   int n_chk = 0;

   logic [7:0] src_data[$];
   logic       src_last[$];
   int         src_limit;
   int         src_acc;

   logic [1:0] lp_log[$];
   logic       en_log[$];
   logic [7:0] by_log[$];
   logic       bsy_log[$];
   logic       und_log[$];
   logic       rdy_log[$];
   logic [7:0] burst_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_src();
      if (src_data.size() > 0 && (src_limit < 0 || src_acc < src_limit)) begin
         valid   = 1'b1;
         byte_in = src_data[0];
         last    = src_last[0];
      end else begin
         valid   = 1'b0;
         byte_in = 8'h00;
         last    = 1'b0;
      end
   endtask

   task automatic push(input logic [7:0] b, input logic l);
      src_data.push_back(b);
      src_last.push_back(l);
   endtask

   // One clock: handshake decided before the edge, outputs sampled 1 ns after
   task automatic step();
      logic fire;
      fire = ready && valid;
      @(posedge clk);
      #1;
      if (fire) begin
         void'(src_data.pop_front());
         void'(src_last.pop_front());
         src_acc++;
      end
      lp_log.push_back(lp);
      en_log.push_back(hs_en);
      by_log.push_back(hs_byte);
      bsy_log.push_back(busy);
      und_log.push_back(underflow);
      rdy_log.push_back(ready);
      drive_src();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic clear_logs();
      lp_log.delete(); en_log.delete(); by_log.delete();
      bsy_log.delete(); und_log.delete(); rdy_log.delete();
   endtask

   task automatic do_reset();
      src_data.delete();
      src_last.delete();
      src_limit = -1;
      src_acc   = 0;
      reset_n   = 1'b0;
      drive_src();
      step();
      step();
      reset_n = 1'b1;
      clear_logs();
   endtask

   // Collect the HS bytes of the k-th hs_en run in the log
   task automatic fill_burst(input int k);
      int   r;
      logic prev;
      burst_q.delete();
      r    = -1;
      prev = 1'b0;
      foreach (en_log[i]) begin
         if (en_log[i] && !prev) r++;
         if (en_log[i] && r == k) burst_q.push_back(by_log[i]);
         prev = en_log[i];
      end
   endtask

   function automatic int burst_end(input int k);
      int   r;
      int   e;
      logic prev;
      r    = -1;
      e    = -1;
      prev = 1'b0;
      foreach (en_log[i]) begin
         if (en_log[i] && !prev) r++;
         if (en_log[i] && r == k) e = i;
         prev = en_log[i];
      end
      return e;
   endfunction

   task automatic check_burst(input string tag, input int k, input logic [7:0] exp[$]);
      fill_burst(k);
      check($sformatf("%s_len", tag), burst_q.size(), exp.size());
      foreach (exp[i]) begin
         check($sformatf("%s_b%0d", tag, i), (i < burst_q.size()) ? burst_q[i] : 8'hxx, exp[i]);
      end
   endtask

   function automatic int count_ones(input logic q[$]);
      int n = 0;
      foreach (q[i]) if (q[i] === 1'b1) n++;
      return n;
   endfunction

   initial begin
      int         e;
      int         n11;
      int         nrdy;
      int         acc0;
      int         p;
      logic       found;
      logic [7:0] w;
      logic       bits[$];
      logic [7:0] exp_q[$];

      reset_n = 1'b0;
      valid   = 1'b0;
      byte_in = 8'h00;
      last    = 1'b0;
      src_limit = -1;
      src_acc   = 0;

      // ---------------- reset state ----------------
      do_reset();
      check("rst_lp", lp, 2'b11);
      check("rst_hs_en", hs_en, 1'b0);
      check("rst_hs_byte", hs_byte, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_underflow", underflow, 1'b0);
      check("rst_ready", ready, 1'b0);

      // ---------------- 3-byte burst ----------------
      push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b1);
      drive_src();
      run(28);
      check("t1_lp_c1", lp_log[0], 2'b11);
      check("t1_lp01_a", lp_log[1], 2'b01);
      check("t1_lp01_b", lp_log[2], 2'b01);
      check("t1_lp00_a", lp_log[3], 2'b00);
      check("t1_lp00_b", lp_log[4], 2'b00);
      check("t1_hs_off_lp00", en_log[4], 1'b0);
      check("t1_hs_on", en_log[5], 1'b1);
      exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hB8, 8'h11, 8'h22, 8'h33, 8'hFF, 8'hFF};
      check_burst("t1", 0, exp_q);
      e = burst_end(0);
      check("t1_end_idx", e, 14);
      if (e < 0) e = 0;
      n11 = 0;
      for (int i = e + 1; i <= e + 8 && i < lp_log.size(); i++) begin
         if (lp_log[i] == 2'b11 && !en_log[i] && by_log[i] == 8'h00) n11++;
      end
      check("t1_gap_lp11", n11, 8);
      check("t1_busy_gap", bsy_log[e + 7], 1'b1);
      check("t1_busy_idle", bsy_log[e + 8], 1'b0);
      check("t1_no_underflow", count_ones(und_log), 0);
      check("t1_ready_cycles", count_ones(rdy_log), 3);

      // ---------------- last byte 0x80 ----------------
      do_reset();
      push(8'h80, 1'b1);
      drive_src();
      run(25);
      exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hB8, 8'h80, 8'h00, 8'h00};
      check_burst("t2", 0, exp_q);

      // ---------------- starvation before any payload ----------------
      do_reset();
      push(8'h55, 1'b1);
      drive_src();
      step();
      src_limit = 0;
      drive_src();
      run(22);
      exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hB8, 8'h00, 8'h00};
      check_burst("t2b", 0, exp_q);
      check("t2b_underflow_cnt", count_ones(und_log), 1);

      // ---------------- underflow after first byte ----------------
      do_reset();
      push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b1);
      src_limit = 1;
      drive_src();
      run(24);
      src_limit = -1;
      drive_src();
      run(30);
      exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hB8, 8'h11, 8'hFF, 8'hFF};
      check_burst("t3a", 0, exp_q);
      exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hB8, 8'h22, 8'h33, 8'hFF, 8'hFF};
      check_burst("t3b", 1, exp_q);
      check("t3_underflow_at", und_log[11], 1'b1);
      check("t3_underflow_cnt", count_ones(und_log), 1);

      // ---------------- reset during DATA ----------------
      do_reset();
      push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0);
      push(8'h04, 1'b0); push(8'h05, 1'b1);
      drive_src();
      for (int g = 0; g < 30 && !ready; g++) step();
      check("t4_reach_data", ready, 1'b1);
      step();
      acc0 = src_acc;
      check("t4_acc_before", acc0, 1);
      reset_n = 1'b0;
      #1;
      check("t4_ready_in_rst", ready, 1'b0);
      step();
      reset_n = 1'b1;
      check("t4_lp", lp, 2'b11);
      check("t4_hs_en", hs_en, 1'b0);
      check("t4_hs_byte", hs_byte, 8'h00);
      check("t4_busy", busy, 1'b0);
      check("t4_underflow", underflow, 1'b0);
      check("t4_no_accept", src_acc, acc0);
      clear_logs();
      run(4);
      check("t4_no_trail", count_ones(en_log), 0);

      // ---------------- back-to-back bursts ----------------
      do_reset();
      push(8'hA1, 1'b0); push(8'hA2, 1'b1);
      push(8'hB1, 1'b0); push(8'hB2, 1'b1);
      drive_src();
      run(45);
      exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hB8, 8'hA1, 8'hA2, 8'h00, 8'h00};
      check_burst("t5a", 0, exp_q);
      exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hB8, 8'hB1, 8'hB2, 8'h00, 8'h00};
      check_burst("t5b", 1, exp_q);
      e = burst_end(0);
      if (e < 0) e = 0;
      n11  = 0;
      nrdy = 0;
      p    = e + 1;
      while (p < lp_log.size() && lp_log[p] == 2'b11) begin
         n11++;
         if (rdy_log[p]) nrdy++;
         p++;
      end
      check("t5_gap_len", n11, 8);
      check("t5_gap_ready", nrdy, 0);
      check("t5_next_lp01", (p < lp_log.size()) ? lp_log[p] : 2'bxx, 2'b01);

      // ---------------- loopback: serialize, deserialize, align ----------------
      fill_burst(1);
      bits.delete();
      bits.push_back(1'b1); bits.push_back(1'b0); bits.push_back(1'b1);
      foreach (burst_q[i]) begin
         w = burst_q[i];
         for (int b = 0; b < 8; b++) bits.push_back(w[b]);
      end
      found = 1'b0;
      p     = 0;
      while (!found && p + 8 <= bits.size()) begin
         for (int b = 0; b < 8; b++) w[b] = bits[p + b];
         if (w == 8'hB8) found = 1'b1;
         else p++;
      end
      check("t6_sync_found", found, 1'b1);
      exp_q = '{8'hB8, 8'hB1, 8'hB2};
      foreach (exp_q[k]) begin
         w = 8'h00;
         for (int b = 0; b < 8; b++) begin
            if (p + 8 * k + b < bits.size()) w[b] = bits[p + 8 * k + b];
         end
         check($sformatf("t6_aligned_%0d", k), w, exp_q[k]);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
